// File: rtl/button_pulse_conditioner_if.sv
// Button-side signal bundle for the pulse conditioner: the raw button and repeat
// controls toward the block, and the conditioned level, pulses and debug state back.
interface button_pulse_conditioner_if;
  logic       button;
  logic       repeat_en;
  logic       level;
  logic       pulse;
  logic       rel;
  logic [2:0] state;

  modport master (output button, output repeat_en,
                  input level, input pulse, input rel, input state);
  modport slave  (input button, input repeat_en,
                  output level, output pulse, output rel, output state);
endinterface

// File: rtl/button_pulse_conditioner.sv
// Synchronizes and debounces a raw push-button, emitting one count-enable pulse per
// press, optional auto-repeat pulses while held, and a pulse on accepted release.
module button_pulse_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 20000,
  parameter int REPEAT_PERIOD   = 5000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_button,
  input  logic       i_repeat_en,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_release,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   release_q, release_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_button};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
    end
  end

  // The synchronized level is tested before the limit, so an abort beats completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (!i_repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == DLY_LAST) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (!i_repeat_en) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        // A bounce back to pressed returns to HELD with the repeat timer restarted.
        if (s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_level   = level_q;
  assign o_pulse   = pulse_q;
  assign o_release = release_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner: a per-edge vector table for a clean
// press/release, then hand-written bounce, repeat, glitch, reset and counting sequences.
module tb_button_pulse_conditioner;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  button_pulse_conditioner_if bif ();

  button_pulse_conditioner #(
    .SYNC_STAGES    (2),
    .CNT_W          (8),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_button   (bif.button),
    .i_repeat_en(bif.repeat_en),
    .o_level    (bif.level),
    .o_pulse    (bif.pulse),
    .o_release  (bif.rel),
    .o_state    (bif.state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic       r;
    logic       p;
    logic       rl;
    logic       lv;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic b, input logic r);
    bif.button    = b;
    bif.repeat_en = r;
    @(posedge clk);
    #1;
    check("pulse_release_exclusive", {63'd0, bif.pulse & bif.rel}, 64'd0);
  endtask

  task automatic add_vec(input logic b, input logic r, input logic p, input logic rl,
                         input logic lv, input logic [2:0] st);
    vec_t v;
    v.b = b; v.r = r; v.p = p; v.rl = rl; v.lv = lv; v.st = st;
    vecs.push_back(v);
  endtask

  logic [63:0] pm, rm;
  logic [2:0]  st_a, st_b;
  logic        lv_all;
  logic [7:0]  count8;
  int          pulses, releases, first;

  initial begin
    // Clean press, repeat off: press edges 1..12, then release edges 1..10.
    add_vec(1,0,0,0,0,3'd0); add_vec(1,0,0,0,0,3'd0); add_vec(1,0,0,0,0,3'd1);
    add_vec(1,0,0,0,0,3'd1); add_vec(1,0,0,0,0,3'd1); add_vec(1,0,0,0,0,3'd1);
    add_vec(1,0,1,0,1,3'd2); add_vec(1,0,0,0,1,3'd2); add_vec(1,0,0,0,1,3'd2);
    add_vec(1,0,0,0,1,3'd2); add_vec(1,0,0,0,1,3'd2); add_vec(1,0,0,0,1,3'd2);
    add_vec(0,0,0,0,1,3'd2); add_vec(0,0,0,0,1,3'd2); add_vec(0,0,0,0,1,3'd4);
    add_vec(0,0,0,0,1,3'd4); add_vec(0,0,0,0,1,3'd4); add_vec(0,0,0,0,1,3'd4);
    add_vec(0,0,0,1,0,3'd0); add_vec(0,0,0,0,0,3'd0); add_vec(0,0,0,0,0,3'd0);
    add_vec(0,0,0,0,0,3'd0);

    rst_n         = 1'b0;
    bif.button    = 1'b0;
    bif.repeat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level",   {63'd0, bif.level}, 64'd0);
    check("reset_pulse",   {63'd0, bif.pulse}, 64'd0);
    check("reset_release", {63'd0, bif.rel},   64'd0);
    check("reset_state",   {61'd0, bif.state}, 64'd0);
    #3 rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].b, vecs[i].r);
      check($sformatf("t1_pulse[%0d]", i),   {63'd0, bif.pulse}, {63'd0, vecs[i].p});
      check($sformatf("t1_release[%0d]", i), {63'd0, bif.rel},   {63'd0, vecs[i].rl});
      check($sformatf("t1_level[%0d]", i),   {63'd0, bif.level}, {63'd0, vecs[i].lv});
      check($sformatf("t1_state[%0d]", i),   {61'd0, bif.state}, {61'd0, vecs[i].st});
    end

    // Bounce: 1 x3, 0 x2, then steady 1 from edge 6; pulse expected at 6+6.
    pulses = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle((i <= 3) || (i >= 6), 1'b0);
      if (bif.pulse) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("bounce_pulse_count", 64'(pulses), 64'd1);
    check("bounce_pulse_edge",  64'(first),  64'd12);
    releases = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b0);
      if (bif.rel) releases++;
    end
    check("bounce_release_count", 64'(releases), 64'd1);
    check("bounce_idle_state", {61'd0, bif.state}, 64'd0);

    // Auto-repeat: held before edges 1..24; the would-be pulse at 27 is aborted by release.
    pm = '0; rm = '0;
    for (int i = 1; i <= 40; i++) begin
      cycle(i <= 24, 1'b1);
      pm[i] = bif.pulse;
      rm[i] = bif.rel;
    end
    check("repeat_pulse_edges",   pm, 64'h0000_0000_0124_8080);
    check("repeat_release_edges", rm, 64'h0000_0000_8000_0000);
    check("repeat_end_level", {63'd0, bif.level}, 64'd0);
    check("repeat_end_state", {61'd0, bif.state}, 64'd0);

    // Release glitch in HELD with repeat enabled: timer restarts on return to HELD.
    repeat (10) cycle(1'b1, 1'b0);
    check("glitch_pre_state", {61'd0, bif.state}, 64'd2);
    pm = '0; rm = '0; lv_all = 1'b1; st_a = '0; st_b = '0;
    for (int i = 1; i <= 16; i++) begin
      cycle(!((i >= 1) && (i <= 3)), 1'b1);
      pm[i]  = bif.pulse;
      rm[i]  = bif.rel;
      lv_all = lv_all & bif.level;
      if (i == 3) st_a = bif.state;
      if (i == 6) st_b = bif.state;
    end
    check("glitch_rw_state",     {61'd0, st_a}, 64'd4);
    check("glitch_held_state",   {61'd0, st_b}, 64'd2);
    check("glitch_pulse_edges",  pm, 64'h0000_0000_0000_4000);
    check("glitch_no_release",   rm, 64'd0);
    check("glitch_level_kept",   {63'd0, lv_all}, 64'd1);
    cycle(1'b1, 1'b0);
    check("repeat_off_to_held", {61'd0, bif.state}, 64'd2);
    repeat (10) cycle(1'b0, 1'b0);
    check("glitch_end_state", {61'd0, bif.state}, 64'd0);

    // Asynchronous reset while HELD, button still pressed afterwards.
    repeat (10) cycle(1'b1, 1'b0);
    check("rst_pre_level", {63'd0, bif.level}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_level", {63'd0, bif.level}, 64'd0);
    check("rst_async_state", {61'd0, bif.state}, 64'd0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("rst_held_state", {61'd0, bif.state}, 64'd0);
    #4 rst_n = 1'b1;
    pulses = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b0);
      if (bif.pulse) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("rst_fresh_pulse_count", 64'(pulses), 64'd1);
    check("rst_fresh_pulse_edge",  64'(first),  64'd7);
    repeat (10) cycle(1'b0, 1'b0);

    // Five bouncy presses feeding a counter_8bit-style enable counter.
    count8 = '0; releases = 0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 30; i++) begin
        cycle((i < 2) || ((i >= 3) && (i < 15)) || (i == 17), 1'b0);
        if (bif.pulse) count8 = count8 + 8'd1;
        if (bif.rel) releases++;
      end
    end
    check("counter_count", {56'd0, count8}, 64'd5);
    check("counter_releases", 64'(releases), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
